// File: rtl/detector_paridade_quadro.sv
// Framed serial parity checker: DATA_W data bits LSB first, then one parity bit.
// Selectable even/odd sense per frame, abort on re-sync, saturating error counter.
module detector_paridade_quadro #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              odd_mode,
  input  logic              serial_valid,
  input  logic              serial_input,
  input  logic              clear_count,
  output logic              busy,
  output logic              paridade_parcial,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_done,
  output logic              parity_error,
  output logic              frame_aborted,
  output logic [CNT_W-1:0]  error_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_par, w_par_nxt;
  logic              r_odd, w_odd_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_perr, w_perr_nxt;
  logic              r_done, w_done_nxt;
  logic              r_abort, w_abort_nxt;
  logic [CNT_W-1:0]  r_errcnt, w_errcnt_nxt;
  logic              w_err;
  logic              w_inc;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_odd_nxt    = r_odd;
    w_data_nxt   = r_data;
    w_perr_nxt   = r_perr;
    w_done_nxt   = 1'b0;
    w_abort_nxt  = 1'b0;
    w_err        = 1'b0;
    w_inc        = 1'b0;

    if (frame_start) begin
      // Re-sync wins over everything, including a bit arriving this cycle.
      w_state_nxt = S_DATA;
      w_cnt_nxt   = '0;
      w_par_nxt   = 1'b0;
      w_odd_nxt   = odd_mode;
      w_abort_nxt = (r_state != S_IDLE);
    end else begin
      unique case (r_state)
        S_DATA: begin
          if (serial_valid) begin
            w_shift_nxt = {serial_input, r_shift[DATA_W-1:1]};
            w_par_nxt   = r_par ^ serial_input;
            if (r_cnt == LAST_IDX) begin
              w_state_nxt = S_PARITY;
            end else begin
              w_cnt_nxt = r_cnt + IDX_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (serial_valid) begin
            w_err       = ((r_par ^ serial_input) != r_odd);
            w_data_nxt  = r_shift;
            w_perr_nxt  = w_err;
            w_done_nxt  = 1'b1;
            w_inc       = w_err;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
        end
      endcase
    end

    // A clear request overrides a same-cycle increment.
    if (clear_count) begin
      w_errcnt_nxt = '0;
    end else if (w_inc) begin
      w_errcnt_nxt = sat_inc(r_errcnt);
    end else begin
      w_errcnt_nxt = r_errcnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_odd    <= 1'b0;
      r_data   <= '0;
      r_perr   <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_errcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_odd    <= w_odd_nxt;
      r_data   <= w_data_nxt;
      r_perr   <= w_perr_nxt;
      r_done   <= w_done_nxt;
      r_abort  <= w_abort_nxt;
      r_errcnt <= w_errcnt_nxt;
    end
  end

  assign busy             = (r_state != S_IDLE);
  assign paridade_parcial = r_par;
  assign data_out         = r_data;
  assign frame_done       = r_done;
  assign parity_error     = r_perr;
  assign frame_aborted    = r_abort;
  assign error_count      = r_errcnt;

endmodule

// File: tb/tb_detector_paridade_quadro.sv
// Self-checking bench for detector_paridade_quadro: directed frames plus random
// traffic, checked against a frame-level reference model built on a bit queue.
module tb_detector_paridade_quadro;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              frame_start = 1'b0;
  logic              odd_mode = 1'b0;
  logic              serial_valid = 1'b0;
  logic              serial_input = 1'b0;
  logic              clear_count = 1'b0;

  logic              busy, paridade_parcial, frame_done, parity_error, frame_aborted;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        error_count;
  logic              busy2, pp2, done2, perr2, abort2;
  logic [DATA_W-1:0] data2;
  logic [1:0]        error_count2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: a frame is just the list of bits accepted so far.
  bit                m_active = 0;
  bit                m_odd = 0;
  bit                m_bits[$];
  bit                exp_done = 0, exp_abort = 0, exp_perr = 0, exp_pp = 0;
  logic [DATA_W-1:0] exp_data = '0;
  int                exp_cnt = 0, exp_cnt2 = 0;

  detector_paridade_quadro #(.DATA_W(DATA_W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .odd_mode(odd_mode),
    .serial_valid(serial_valid), .serial_input(serial_input), .clear_count(clear_count),
    .busy(busy), .paridade_parcial(paridade_parcial), .data_out(data_out),
    .frame_done(frame_done), .parity_error(parity_error), .frame_aborted(frame_aborted),
    .error_count(error_count)
  );

  detector_paridade_quadro #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .odd_mode(odd_mode),
    .serial_valid(serial_valid), .serial_input(serial_input), .clear_count(clear_count),
    .busy(busy2), .paridade_parcial(pp2), .data_out(data2),
    .frame_done(done2), .parity_error(perr2), .frame_aborted(abort2),
    .error_count(error_count2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0; m_odd = 0; m_bits.delete();
    exp_done = 0; exp_abort = 0; exp_perr = 0; exp_pp = 0;
    exp_data = '0; exp_cnt = 0; exp_cnt2 = 0;
  endtask

  // Drive one cycle, advance the model across the edge, land 1 time unit after it.
  task automatic step(input bit fs, input bit odd, input bit sv, input bit si, input bit cc);
    int ones;
    logic [DATA_W-1:0] w;
    bit err;
    frame_start = fs; odd_mode = odd; serial_valid = sv; serial_input = si; clear_count = cc;
    @(posedge clk);
    exp_done = 0; exp_abort = 0;
    if (fs) begin
      exp_abort = m_active;
      m_active = 1; m_odd = odd; m_bits.delete();
    end else if (m_active && sv) begin
      if (m_bits.size() < DATA_W) begin
        m_bits.push_back(si);
      end else begin
        ones = 0; w = '0;
        foreach (m_bits[i]) begin w[i] = m_bits[i]; ones += m_bits[i]; end
        err = (((ones + si) % 2) == 1) != m_odd;
        exp_data = w; exp_perr = err; exp_done = 1; m_active = 0;
        if (err) begin
          if (exp_cnt < 255) exp_cnt++;
          if (exp_cnt2 < 3) exp_cnt2++;
        end
      end
    end
    if (cc) begin exp_cnt = 0; exp_cnt2 = 0; end
    exp_pp = 0;
    foreach (m_bits[i]) exp_pp ^= m_bits[i];
    #1;
  endtask

  // odd_mode is randomised on every non-start cycle: only the value at frame_start may matter.
  task automatic send_frame(input logic [DATA_W-1:0] word, input bit pbit, input bit odd,
                            input int maxgap, input bit cc_last);
    step(1, odd, 0, 0, 0);
    for (int i = 0; i <= DATA_W; i++) begin
      for (int g = $urandom_range(0, maxgap); g > 0; g--)
        step(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0);
      step(0, 1'($urandom_range(0, 1)), 1, (i < DATA_W) ? word[i] : pbit,
           (i == DATA_W) ? cc_last : 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, paridade_parcial, data_out, frame_done, parity_error, frame_aborted, error_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b pp=%b data=%h done=%b perr=%b abort=%b cnt=%0d, want all 0",
                         busy, paridade_parcial, data_out, frame_done, parity_error, frame_aborted, error_count);
    end
    n_checks++;
    if (error_count2 !== 2'd0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut2: got cnt=%0d busy=%b, want 0 0", error_count2, busy2);
    end
    @(negedge clk); reset = 1;
    model_reset();
  endtask

  task automatic test_even_frame();
    send_frame(8'hA5, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (frame_done !== 1'b1 || data_out !== 8'hA5 || parity_error !== 1'b0 || error_count !== 8'd0) begin
      n_fail++; $display("FAIL even_A5: got done=%b data=%h perr=%b cnt=%0d, want 1 a5 0 0",
                         frame_done, data_out, parity_error, error_count);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || data_out !== 8'hA5) begin
      n_fail++; $display("FAIL even_done_pulse: got done=%b busy=%b data=%h, want 0 0 a5", frame_done, busy, data_out);
    end
  endtask

  task automatic test_parity_error();
    bit pp_ref [8] = '{1, 1, 0, 0, 0, 1, 1, 0};
    logic [7:0] word = 8'hA5;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1, word[i], 0);
      n_checks++;
      if (paridade_parcial !== pp_ref[i] || paridade_parcial !== exp_pp) begin
        n_fail++; $display("FAIL running_parity bit%0d: got %b, want %b", i, paridade_parcial, pp_ref[i]);
      end
    end
    step(0, 0, 1, 1, 0);
    n_checks++;
    if (frame_done !== 1'b1 || parity_error !== 1'b1 || error_count !== 8'd1 || data_out !== 8'hA5) begin
      n_fail++; $display("FAIL even_A5_bad: got done=%b perr=%b cnt=%0d data=%h, want 1 1 1 a5",
                         frame_done, parity_error, error_count, data_out);
    end
  endtask

  task automatic test_odd_mode();
    send_frame(8'h07, 1'b0, 1'b1, 0, 0);
    n_checks++;
    if (frame_done !== 1'b1 || data_out !== 8'h07 || parity_error !== 1'b0) begin
      n_fail++; $display("FAIL odd_07_good: got done=%b data=%h perr=%b, want 1 07 0", frame_done, data_out, parity_error);
    end
    send_frame(8'h07, 1'b1, 1'b1, 0, 0);
    n_checks++;
    if (frame_done !== 1'b1 || parity_error !== 1'b1 || error_count !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL odd_07_bad: got done=%b perr=%b cnt=%0d, want 1 1 %0d",
                         frame_done, parity_error, error_count, exp_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] word = 8'h3C;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      for (int g = $urandom_range(1, 3); g > 0; g--) begin
        step(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0);
        n_checks++;
        if (busy !== 1'b1 || frame_done !== 1'b0) begin
          n_fail++; $display("FAIL gap_busy bit%0d: got busy=%b done=%b, want 1 0", i, busy, frame_done);
        end
      end
      step(0, 1'($urandom_range(0, 1)), 1, (i < 8) ? word[i] : 1'b0, 0);
    end
    n_checks++;
    if (frame_done !== 1'b1 || data_out !== 8'h3C || parity_error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL gap_3C: got done=%b data=%h perr=%b busy=%b, want 1 3c 0 0",
                         frame_done, data_out, parity_error, busy);
    end
  endtask

  task automatic test_abort();
    logic [7:0] word = 8'hFF;
    logic [7:0] held;
    held = data_out;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, word[i], 0);
    step(1, 0, 1, 1, 0);
    n_checks++;
    if (frame_aborted !== 1'b1 || frame_done !== 1'b0 || data_out !== held || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_pulse: got abort=%b done=%b data=%h busy=%b, want 1 0 %h 1",
                         frame_aborted, frame_done, data_out, busy, held);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (frame_aborted !== 1'b0 || paridade_parcial !== 1'b0) begin
      n_fail++; $display("FAIL abort_one_cycle: got abort=%b pp=%b, want 0 0", frame_aborted, paridade_parcial);
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1, 0);
    n_checks++;
    if (frame_done !== 1'b1 || data_out !== 8'h5A || parity_error !== 1'b0) begin
      n_fail++; $display("FAIL after_abort_5A: got done=%b data=%h perr=%b, want 1 5a 0", frame_done, data_out, parity_error);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h81, 1'b1, 1'b0, 0, 0);
    step(1, 1, 1, 1, 0);
    n_checks++;
    if (frame_aborted !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start: got abort=%b busy=%b done=%b, want 0 1 0", frame_aborted, busy, frame_done);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1'(i % 3 == 0), 0);
    step(0, 0, 1, 1, 0);
    n_checks++;
    if (frame_done !== 1'b1 || data_out !== exp_data || parity_error !== exp_perr || data_out !== 8'h49) begin
      n_fail++; $display("FAIL b2b_frame: got data=%h perr=%b, want 49 %b", data_out, parity_error, exp_perr);
    end
  endtask

  task automatic test_reset_midframe();
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    @(negedge clk); reset = 0; #1;
    n_checks++;
    if ({busy, paridade_parcial, data_out, frame_done, parity_error, frame_aborted, error_count} !== '0) begin
      n_fail++; $display("FAIL reset_midframe: got busy=%b pp=%b data=%h done=%b perr=%b abort=%b cnt=%0d, want all 0",
                         busy, paridade_parcial, data_out, frame_done, parity_error, frame_aborted, error_count);
    end
    @(posedge clk); #1;
    n_checks++;
    if (frame_done !== 1'b0 || frame_aborted !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_pulse: got done=%b abort=%b, want 0 0", frame_done, frame_aborted);
    end
    @(negedge clk); reset = 1;
    model_reset();
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) send_frame(8'(k * 37), 1'(~^(8'(k * 37))), 1'b0, 0, 0);
    n_checks++;
    if (error_count2 !== 2'd3 || error_count !== 8'd5) begin
      n_fail++; $display("FAIL saturate: got cnt2=%0d cnt8=%0d, want 3 5", error_count2, error_count);
    end
    send_frame(8'h11, 1'b1, 1'b0, 0, 1);
    n_checks++;
    if (parity_error !== 1'b1 || error_count !== 8'd0 || error_count2 !== 2'd0) begin
      n_fail++; $display("FAIL clear_wins: got perr=%b cnt8=%0d cnt2=%0d, want 1 0 0",
                         parity_error, error_count, error_count2);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
      n_checks++;
      if (frame_done !== exp_done || frame_aborted !== exp_abort || parity_error !== exp_perr ||
          data_out !== exp_data || busy !== m_active || error_count !== 8'(exp_cnt) ||
          error_count2 !== 2'(exp_cnt2) || (m_active && paridade_parcial !== exp_pp)) begin
        n_fail++;
        $display("FAIL random c%0d: got done=%b abort=%b perr=%b data=%h busy=%b pp=%b cnt=%0d cnt2=%0d, want %b %b %b %h %b %b %0d %0d",
                 c, frame_done, frame_aborted, parity_error, data_out, busy, paridade_parcial, error_count, error_count2,
                 exp_done, exp_abort, exp_perr, exp_data, m_active, exp_pp, exp_cnt, exp_cnt2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_frame();
    test_parity_error();
    test_odd_mode();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
